// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: receiver state encoding, frame geometry and
// default timing parameters used by the host-side PS/2 port blocks.
package ps2_pkg;

    localparam int PS2_DATA_BITS       = 8;
    localparam int PS2_FRAME_BITS      = 11;      // start + 8 data + parity + stop
    localparam int PS2_FILTER_LEN_DEF  = 8;
    localparam int PS2_TIMEOUT_CYC_DEF = 100000;  // 2 ms at 50 MHz
    localparam int PS2_TMO_W           = 17;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchroniser, FILTER_LEN-sample debounce and a
// one-Clk strobe on each filtered 1->0 transition. The line idles high, so
// every register resets to 1 except the counter and the strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_line,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_differs;
    logic          w_flip;

    assign w_differs = (r_sync2 != r_level);
    assign w_flip    = w_differs && (r_cnt == CW'(FILTER_LEN - 1));
    assign o_fall    = r_fall;

    // Bring the asynchronous pad into the Clk domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the filtered level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_fall <= w_flip && r_level;
            if (w_flip) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: deserialises device-to-host frames (start, 8 data bits
// LSB first, odd parity, stop) and reports each frame as exactly one pulse on
// Valid, ParityErr or FrameErr. Never drives the bus.
// Optional inter-edge timeout: define PS2_RX_TIMEOUT_EN.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    input  logic       Enable,
    output logic [7:0] DataOut,
    output logic       Valid,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Busy
);

    if (FILTER_LEN < 2 || FILTER_LEN > 16) begin : g_bad_filter_len
        $error("ps2_host_rx: FILTER_LEN must be in 2..16");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC >= (1 << PS2_TMO_W)) begin : g_bad_timeout
        $error("ps2_host_rx: TIMEOUT_CYC must fit the timeout counter");
    end

    rx_state_t                 r_state, w_state_next;
    logic [2:0]                r_cnt, w_cnt_next;
    logic [PS2_DATA_BITS-1:0]  r_shreg, w_shreg_next;
    logic                      r_par, w_par_next;
    logic [PS2_DATA_BITS-1:0]  r_dout, w_dout_next;
    logic                      r_valid, w_valid_next;
    logic                      r_perr, w_perr_next;
    logic                      r_ferr, w_ferr_next;
    logic                      r_data_s1, r_data_s2;
    logic                      w_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_line (PS2Clk),
        .o_fall (w_fall)
    );

    // Data line is only synchronised: it is sampled on the filtered clock edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_data_s1 <= PS2Data;
            r_data_s2 <= r_data_s1;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    logic [PS2_TMO_W-1:0] r_tmo;
    logic                 w_tmo_hit;

    assign w_tmo_hit = (r_state != RX_IDLE) && (r_tmo == PS2_TMO_W'(TIMEOUT_CYC - 1));

    // Inter-edge watchdog: restarts on every fall and while idle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tmo <= '0;
        end else if (r_state == RX_IDLE || w_fall) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + PS2_TMO_W'(1);
        end
    end
`endif

    // Next-state and result logic; Enable low overrides any edge activity.
    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shreg_next = r_shreg;
        w_par_next   = r_par;
        w_dout_next  = r_dout;
        w_valid_next = 1'b0;
        w_perr_next  = 1'b0;
        w_ferr_next  = 1'b0;
        if (!Enable) begin
            w_state_next = RX_IDLE;
            w_cnt_next   = '0;
        end else if (w_fall) begin
            unique case (r_state)
                RX_IDLE: begin
                    if (!r_data_s2) begin
                        w_state_next = RX_DATA;
                        w_cnt_next   = '0;
                    end
                end
                RX_DATA: begin
                    w_shreg_next = {r_data_s2, r_shreg[PS2_DATA_BITS-1:1]};
                    w_cnt_next   = r_cnt + 3'd1;
                    if (r_cnt == 3'(PS2_DATA_BITS - 1)) begin
                        w_state_next = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    w_par_next   = r_data_s2;
                    w_state_next = RX_STOP;
                end
                RX_STOP: begin
                    w_state_next = RX_IDLE;
                    w_cnt_next   = '0;
                    if (!r_data_s2) begin
                        w_ferr_next = 1'b1;
                    end else if (!odd_parity_ok(r_shreg, r_par)) begin
                        w_perr_next = 1'b1;
                    end else begin
                        w_dout_next  = r_shreg;
                        w_valid_next = 1'b1;
                    end
                end
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        else if (w_tmo_hit) begin
            w_state_next = RX_IDLE;
            w_cnt_next   = '0;
            w_ferr_next  = 1'b1;
        end
`endif
    end

    // Receiver state, shift register and registered result pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shreg <= w_shreg_next;
            r_par   <= w_par_next;
            r_dout  <= w_dout_next;
            r_valid <= w_valid_next;
            r_perr  <= w_perr_next;
            r_ferr  <= w_ferr_next;
        end
    end

    assign DataOut   = r_dout;
    assign Valid     = r_valid;
    assign ParityErr = r_perr;
    assign FrameErr  = r_ferr;
    assign Busy      = (r_state != RX_IDLE);

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: drives PS/2 device frames on the pads and
// counts result pulses in a monitor. Build with +define+PS2_RX_TIMEOUT_EN to
// exercise the inter-edge timeout.
module tb_ps2_host_rx;

    localparam int HALF_BIT = 40;  // PS2Clk half period in Clk cycles

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       PS2Clk = 1'b1;
    logic       PS2Data = 1'b1;
    logic       Enable = 1'b1;
    logic [7:0] DataOut;
    logic       Valid;
    logic       ParityErr;
    logic       FrameErr;
    logic       Busy;

    int n_checks = 0;
    int n_pass   = 0;

    int         n_valid = 0;
    int         n_perr  = 0;
    int         n_ferr  = 0;
    logic [7:0] vdata [0:15];

    int exp_valid = 0;
    int exp_perr  = 0;
    int exp_ferr  = 0;

    ps2_host_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(1000)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .Enable    (Enable),
        .DataOut   (DataOut),
        .Valid     (Valid),
        .ParityErr (ParityErr),
        .FrameErr  (FrameErr),
        .Busy      (Busy)
    );

    always #10 Clk = ~Clk;  // 50 MHz

    // Count every high cycle of each result strobe, away from the active edge.
    always @(negedge Clk) begin
        if (Valid) begin
            vdata[n_valid[3:0]] <= DataOut;
            n_valid <= n_valid + 1;
        end
        if (ParityErr) n_perr <= n_perr + 1;
        if (FrameErr)  n_ferr <= n_ferr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One device bit: data set while the clock is high, then a full clock pulse.
    task automatic send_bit(input logic b, input logic glitch);
        PS2Data = b;
        if (glitch) begin
            wait_clk(HALF_BIT / 4);
            PS2Clk = 1'b0;
            wait_clk(3);
            PS2Clk = 1'b1;
            wait_clk(HALF_BIT / 2 - HALF_BIT / 4 - 3);
        end else begin
            wait_clk(HALF_BIT / 2);
        end
        PS2Clk = 1'b0;
        wait_clk(HALF_BIT);
        PS2Clk = 1'b1;
        wait_clk(HALF_BIT / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int glitch_bit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_bit);
        send_bit(p, 1'b0);
        send_bit(stop, 1'b0);
        PS2Data = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i], 1'b0);
        PS2Data = 1'b1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_valid"}, n_valid, exp_valid);
        check({tag, "_perr"},  n_perr,  exp_perr);
        check({tag, "_ferr"},  n_ferr,  exp_ferr);
    endtask

    initial begin
        wait_clk(5);
        Reset = 1'b0;
        wait_clk(2);
        check("rst_dataout", DataOut, 8'h00);
        check("rst_valid", Valid, 1'b0);
        check("rst_perr", ParityErr, 1'b0);
        check("rst_ferr", FrameErr, 1'b0);
        check("rst_busy", Busy, 1'b0);

        // 1: 0xAA (four ones), parity 1
        send_frame(8'hAA, 1'b1, 1'b1, -1);
        wait_clk(5);
        exp_valid++;
        check_counts("t1");
        check("t1_dataout", DataOut, 8'hAA);
        check("t1_busy", Busy, 1'b0);

        // 2: back-to-back 0x01 (p=0) then 0xFF (p=1)
        send_frame(8'h01, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 1'b1, -1);
        wait_clk(5);
        exp_valid += 2;
        check_counts("t2");
        check("t2_first", vdata[1], 8'h01);
        check("t2_second", vdata[2], 8'hFF);
        check("t2_dataout", DataOut, 8'hFF);

        // 3: 0x55 needs parity 1; send 0
        send_frame(8'h55, 1'b0, 1'b1, -1);
        wait_clk(5);
        exp_perr++;
        check_counts("t3");
        check("t3_dataout", DataOut, 8'hFF);

        // 4: 0x12 with good parity but stop bit 0
        send_frame(8'h12, 1'b1, 1'b0, -1);
        wait_clk(5);
        exp_ferr++;
        check_counts("t4");
        check("t4_dataout", DataOut, 8'hFF);
        check("t4_busy", Busy, 1'b0);

        // 5: 3-Clk glitch on PS2Clk during data bit 3 of 0x3C
        send_frame(8'h3C, 1'b1, 1'b1, 3);
        wait_clk(5);
        exp_valid++;
        check_counts("t5");
        check("t5_dataout", DataOut, 8'h3C);

        // 6a: five data bits then stall
        send_partial(8'h15, 5);
        check("t6_busy_mid", Busy, 1'b1);
`ifdef PS2_RX_TIMEOUT_EN
        begin
            int waited = 0;
            while (n_ferr == exp_ferr && waited < 1500) begin
                wait_clk(1);
                waited++;
            end
            exp_ferr++;
            check("t6_tmo_ferr", n_ferr, exp_ferr);
            check("t6_tmo_window", (waited > 850 && waited < 1050), 1'b1);
            wait_clk(3);
            check("t6_tmo_idle", Busy, 1'b0);
        end
`else
        wait_clk(1500);
        check("t6_stall_ferr", n_ferr, exp_ferr);
        check("t6_stall_busy", Busy, 1'b1);
        Enable = 1'b0;
        wait_clk(2);
        Enable = 1'b1;
        check("t6_stall_abort", Busy, 1'b0);
`endif

        // 6b: Enable dropped mid-frame discards it without a pulse
        send_partial(8'h0F, 3);
        check("t6_busy_part", Busy, 1'b1);
        Enable = 1'b0;
        wait_clk(2);
        check("t6_en_idle", Busy, 1'b0);

        // 6c: a whole frame while disabled is ignored
        send_frame(8'h77, 1'b1, 1'b1, -1);
        wait_clk(5);
        check_counts("t6_dis");
        check("t6_dis_dataout", DataOut, 8'h3C);
        Enable = 1'b1;
        wait_clk(5);

        // 6d: Reset mid-frame, then a fresh frame 0x81
        send_partial(8'hA5, 4);
        Reset = 1'b1;
        wait_clk(1);
        check("t6_rst_busy", Busy, 1'b0);
        check("t6_rst_dataout", DataOut, 8'h00);
        wait_clk(2);
        Reset = 1'b0;
        wait_clk(5);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        wait_clk(5);
        exp_valid++;
        check_counts("t6_post");
        check("t6_post_dataout", DataOut, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
